// File: rtl/ha_array_mul_seq_if.sv
// Request, generator and response signals of the ha_array sequencer.
// slave is the sequencer side; master is the requester/generator/consumer side.
interface ha_array_mul_seq_if;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic [7:0] pp_x, pp_y;
  logic [6:0] ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b;
  logic [8:0] ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_p;

  modport slave (
    input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
    input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input  rsp_ready,
    output req0_ready, req1_ready, pp_x, pp_y, rsp_valid, rsp_p, rsp_id
  );

  modport master (
    output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output rsp_ready,
    input  req0_ready, req1_ready, pp_x, pp_y, rsp_valid, rsp_p, rsp_id
  );
endinterface

// File: rtl/ha_array_mul_seq.sv
// Round-robin two-requester sequencer that reduces the four ha_array groups
// into a 16-bit approximate product with one shared accumulator adder.
module ha_array_mul_seq #(
  parameter int GROUPS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst,
  ha_array_mul_seq_if.slave bus
);

  if (GROUPS_PER_CYCLE != 1 && GROUPS_PER_CYCLE != 2 && GROUPS_PER_CYCLE != 4) begin : g_bad_gpc
    $error("GROUPS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [1:0] CNT_STEP = 2'(GROUPS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - GROUPS_PER_CYCLE);

  state_t      state_q;
  logic [15:0] acc_q;
  logic [1:0]  cnt_q;
  logic [7:0]  opx_q, opy_q;
  logic        id_q, last_id_q, rsp_valid_q;

  logic        gnt0, gnt1;
  logic [15:0] gw [4];
  logic [15:0] acc_d;

  function automatic logic [15:0] group_weight(input logic [8:0] t, input logic [6:0] b,
                                               input int unsigned k);
    logic [15:0] s;
    s = 16'(t) + {7'b0, b, 2'b00};
    return s << (2 * k);
  endfunction

  assign gw[0] = group_weight(bus.ha_array_0_t, bus.ha_array_0_b, 0);
  assign gw[1] = group_weight(bus.ha_array_1_t, bus.ha_array_1_b, 1);
  assign gw[2] = group_weight(bus.ha_array_2_t, bus.ha_array_2_b, 2);
  assign gw[3] = group_weight(bus.ha_array_3_t, bus.ha_array_3_b, 3);

  // On a tie the requester that was not served last wins.
  assign gnt0 = !rst && (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_id_q);
  assign gnt1 = !rst && (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_id_q);

  always_comb begin
    logic [1:0] idx;
    acc_d = acc_q;
    for (int j = 0; j < GROUPS_PER_CYCLE; j++) begin
      idx   = cnt_q + 2'(j);
      acc_d = acc_d + gw[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      opx_q       <= '0;
      opy_q       <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            opx_q   <= gnt1 ? bus.req1_x : bus.req0_x;
            opy_q   <= gnt1 ? bus.req1_y : bus.req0_y;
            id_q    <= gnt1;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_STEP;
          if (cnt_q == CNT_LAST) begin
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            last_id_q   <= id_q;
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.pp_x       = opx_q;
  assign bus.pp_y       = opy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_p      = acc_q;
  assign bus.rsp_id     = id_q;

endmodule
